// File: rtl/pipe_skid_reg.sv
`default_nettype none
// pipe_skid_reg: DEPTH cascaded elastic stages, each a main/skid register pair with a
// registered upstream ready, plus global stall/flush and a live occupancy count.
module pipe_skid_reg #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1,
  parameter int CNT_W = $clog2(2*DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occupancy
);

  logic [DEPTH-1:0] w_main_v;
  logic [DEPTH-1:0] w_skid_v;
  logic [DEPTH-1:0] w_rdy;
  logic [WIDTH-1:0] w_main_d [DEPTH];
  logic [CNT_W-1:0] w_occ;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             w_up_v;
    logic [WIDTH-1:0] w_up_d;
    logic             w_dn_rdy;
    logic             w_up_xfer;
    logic             w_dn_xfer;
    logic             r_main_v;
    logic             r_skid_v;
    logic             r_rdy;
    logic [WIDTH-1:0] r_main_d;
    logic [WIDTH-1:0] r_skid_d;

    if (k == 0) begin : g_head
      assign w_up_v = in_valid;
      assign w_up_d = in_data;
    end else begin : g_link
      assign w_up_v = w_main_v[k-1];
      assign w_up_d = w_main_d[k-1];
    end

    if (k == DEPTH-1) begin : g_tail
      assign w_dn_rdy = out_ready;
    end else begin : g_mid
      assign w_dn_rdy = w_rdy[k+1];
    end

    // stall and flush gate these at the branch level of the register update below
    assign w_up_xfer = w_up_v & r_rdy;
    assign w_dn_xfer = r_main_v & w_dn_rdy;

    always_ff @(posedge clk) begin
      if (reset || flush) begin
        r_main_v <= 1'b0;
        r_skid_v <= 1'b0;
        r_rdy    <= 1'b1;
        r_main_d <= '0;
        r_skid_d <= '0;
      end else if (!stall) begin
        if (w_dn_xfer || !r_main_v) begin
          if (r_skid_v) begin
            r_main_d <= r_skid_d;
            r_skid_v <= 1'b0;
            r_rdy    <= 1'b1;
          end else if (w_up_xfer) begin
            r_main_d <= w_up_d;
            r_main_v <= 1'b1;
          end else begin
            r_main_v <= 1'b0;
          end
        end else if (w_up_xfer) begin
          // main is held downstream: park the arrival and stop accepting
          r_skid_d <= w_up_d;
          r_skid_v <= 1'b1;
          r_rdy    <= 1'b0;
        end
      end
    end

    assign w_main_v[k] = r_main_v;
    assign w_skid_v[k] = r_skid_v;
    assign w_rdy[k]    = r_rdy;
    assign w_main_d[k] = r_main_d;
  end

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ = w_occ + CNT_W'(w_main_v[i]) + CNT_W'(w_skid_v[i]);
    end
  end

  assign in_ready  = w_rdy[0] & ~stall;
  assign out_valid = w_main_v[DEPTH-1] & ~stall;
  assign out_data  = w_main_d[DEPTH-1];
  assign occupancy = w_occ;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// Self-checking bench for pipe_skid_reg with DEPTH=2, WIDTH=8: vector table, directed
// corner sequences and a randomized run against a queue-based scoreboard.
module tb_pipe_skid_reg;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] occupancy;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] q[$];

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic       cd;
    logic [7:0] e_od;
    logic [2:0] e_occ;
  } vec_t;
  vec_t tbl[11];

  pipe_skid_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Scoreboard: entries accepted at an edge are queued, emitted entries must match in order.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else begin
      chk("sb_occupancy", 32'(occupancy), 32'(q.size()));
      if (flush) begin
        q.delete();
      end else begin
        if (out_valid && out_ready && !stall) begin
          if (q.size() == 0) chk("sb_unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
          else chk("sb_data", 32'(out_data), 32'(q.pop_front()));
        end
        if (in_valid && in_ready && !stall) q.push_back(in_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic fl, input logic iv, input logic [7:0] d,
                       input logic ordy);
    stall     = st;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic expect_out(input logic e_ir, input logic e_ov, input logic cd,
                            input logic [7:0] e_od, input logic [2:0] e_occ);
    chk("in_ready", 32'(in_ready), 32'(e_ir));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    if (cd) chk("out_data", 32'(out_data), 32'(e_od));
    chk("occupancy", 32'(occupancy), 32'(e_occ));
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic r_ir;
    //           iv    d      ordy  e_ir  e_ov  cd    e_od   e_occ
    tbl[0]  = '{1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 3'd0};
    tbl[1]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 3'd1};
    tbl[2]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA0, 3'd2};
    tbl[3]  = '{1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA0, 3'd3};
    tbl[4]  = '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 3'd4};
    tbl[5]  = '{1'b1, 8'hA4, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA0, 3'd4};
    tbl[6]  = '{1'b1, 8'hA4, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd3};
    tbl[7]  = '{1'b1, 8'hA4, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA2, 3'd2};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA3, 3'd2};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA4, 3'd1};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    #3;
    expect_out(1'b1, 1'b0, 1'b1, 8'h00, 3'd0);
    step();

    // backpressure absorption and in-order release
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, 1'b0, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      #3;
      expect_out(tbl[i].e_ir, tbl[i].e_ov, tbl[i].cd, tbl[i].e_od, tbl[i].e_occ);
      step();
    end

    // pass-through: item c accepted at the end of cycle c appears in cycle c+2
    for (int c = 0; c < 19; c++) begin
      drive(1'b0, 1'b0, c < 16, 8'(c + 1), 1'b1);
      #3;
      chk("pt_in_ready", 32'(in_ready), 32'd1);
      chk("pt_out_valid", 32'(out_valid), 32'((c >= 2) && (c <= 17)));
      if (c >= 2 && c <= 17) chk("pt_out_data", 32'(out_data), 32'(c - 1));
      step();
    end

    // flush with three entries held and a coinciding offer
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 8'(8'h31 + i), 1'b0);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    #3;
    expect_out(1'b1, 1'b1, 1'b1, 8'h31, 3'd3);
    step();
    drive(1'b0, 1'b1, 1'b1, 8'h55, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    #3;
    expect_out(1'b1, 1'b0, 1'b1, 8'h00, 3'd0);
    repeat (3) step();

    // stall holds contents and masks both handshakes
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b1, 8'(8'hB0 + i), 1'b0);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1, 8'hBF, 1'b1);
      #3;
      expect_out(1'b0, 1'b0, 1'b0, 8'h00, 3'd2);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    #3;
    expect_out(1'b1, 1'b1, 1'b1, 8'hB0, 3'd2);
    step();
    #3;
    expect_out(1'b1, 1'b1, 1'b1, 8'hB1, 3'd1);
    step();
    #3;
    expect_out(1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
    step();

    // flush wins over stall
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
      step();
    end
    drive(1'b1, 1'b1, 1'b1, 8'hCC, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    #3;
    expect_out(1'b1, 1'b0, 1'b1, 8'h00, 3'd0);
    step();

    // reset mid-stream at full occupancy
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 8'(8'hD0 + i), 1'b0);
      step();
    end
    drive(1'b0, 1'b0, 1'b1, 8'hDD, 1'b0);
    #3;
    expect_out(1'b0, 1'b1, 1'b1, 8'hD0, 3'd4);
    step();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 8'hDE, 1'b1);
    step();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    #3;
    expect_out(1'b1, 1'b0, 1'b1, 8'h00, 3'd0);
    step();

    // randomized traffic with occasional stall/flush; spot-check in_ready isolation
    for (int n = 0; n < 10000; n++) begin
      drive($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 1, $urandom_range(0, 99) < 70,
            8'($urandom), $urandom_range(0, 99) < 50);
      if (n % 97 == 0) begin
        #1;
        r_ir = in_ready;
        out_ready = ~out_ready;
        #1;
        chk("in_ready_vs_out_ready", 32'(in_ready), 32'(r_ir));
        out_ready = ~out_ready;
      end
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    repeat (12) step();
    chk("drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits, legal range 1..512.
REQ-002 Parameter DEPTH, default 1: number of cascaded elastic stages, legal range 1..8.
REQ-003 Parameter CNT_W, default $clog2(2*DEPTH+1): width of the occupancy output.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port stall, input, 1: freeze; when high, no transfer occurs on either side and all state holds.
REQ-007 Port flush, input, 1: kill all in-flight entries (bubble insertion).
REQ-008 Port in_valid, input, 1: upstream offers in_data.
REQ-009 Port in_data, input, WIDTH: upstream payload.
REQ-010 Port in_ready, output, 1: block can accept; driven directly from a register.
REQ-011 Port out_valid, output, 1: out_data is valid.
REQ-012 Port out_data, output, WIDTH: downstream payload.
REQ-013 Port out_ready, input, 1: downstream accepts.
REQ-014 Port occupancy, output, CNT_W: number of valid entries held, 0..2*DEPTH.

Function
REQ-015 Each stage SHALL contain one main register and one skid register, each with its own valid bit.
REQ-016 A transfer SHALL occur on a side only when valid=1 and ready=1 at a rising edge, with stall=0 and flush=0.
REQ-017 Each stage's upstream ready SHALL equal NOT(skid valid), registered, with no combinational path from out_ready to in_ready.
REQ-018 A stage SHALL load the skid register only when an incoming transfer coincides with main valid=1 and the downstream side not accepting.
REQ-019 When the skid register is valid, it SHALL drain into the main register before any new input is accepted, preserving FIFO order.
REQ-020 Latency SHALL be DEPTH cycles: data accepted at edge N SHALL be presented with out_valid=1 after edge N+DEPTH-1, provided out_ready was continuously 1.
REQ-021 With out_ready held at 1, throughput SHALL be one transfer per cycle, with no bubbles.
REQ-022 With out_ready=0, the block SHALL absorb up to 2*DEPTH entries, then drive in_ready=0.
REQ-023 No entry SHALL be dropped or duplicated under any out_ready pattern.
REQ-024 While stall=1:
- out_valid SHALL read 0;
- in_ready SHALL read 0;
- all registers, including payloads, SHALL hold.
REQ-025 While stall=0, out_valid/out_data SHALL reflect the last stage's main register.
REQ-026 On flush=1 at an edge, all valid bits SHALL clear and all payload registers SHALL load all-zeros.
REQ-027 Flush SHALL override stall.
REQ-028 An entry offered during a flush cycle SHALL be discarded.
REQ-029 in_ready SHALL read 1 in the cycle after a flush.
REQ-030 occupancy SHALL equal the count of set valid bits (main plus skid, all stages), updated every edge.
REQ-031 Simultaneous accept and emit at full occupancy SHALL keep occupancy unchanged.

Reset
REQ-032 Reset SHALL be synchronous and active-high on clk; reset SHALL take priority over flush and stall.
REQ-033 After a reset edge:
- all valid bits = 0; out_valid = 0;
- out_data = 0;
- in_ready = 1;
- occupancy = 0.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight entries, with no output transfer in the reset cycle.

Verification
REQ-035 Pass-through, DEPTH=2, WIDTH=8, out_ready=1: stream 0x01..0x10 -> same sequence on out_data, first at 2 cycles after acceptance, one per cycle.
REQ-036 Backpressure: out_ready=0, offer 0xA0..0xA5 -> 4 accepted, in_ready=0 with occupancy=4; then release -> A0,A1,A2,A3 in order, A4 accepted next.
REQ-037 Random out_ready (50%) and in_valid (70%), 10k cycles -> scoreboard exact order match; in_ready never depends combinationally on out_ready.
REQ-038 Flush with occupancy=3 plus in_valid=1 (data 0x55) -> next cycle occupancy=0, out_valid=0, out_data=0, in_ready=1; 0x55 never emitted.
REQ-039 Stall for 5 cycles with occupancy=2 -> out_valid=0 and in_ready=0 throughout, contents intact; emitted in order after release; flush during stall clears all entries.
REQ-040 Reset mid-stream with occupancy=4 -> next cycle all outputs at reset values per REQ-033.
